wca_rbus_fifo_sched: RTL and testbench
======================================

// Module: wca_rbus_fifo_sched
// PURPOSE
// - Round-robin rbus master that drains up to NCH WcaReadFifo32-style 32w/8r read FIFOs (channel i at rbus addr BASE_ADDR+i).
// - Per grant: reads whole 32-bit words as 4 byte strobes and reassembles each word.
// - Presents each word on a valid/ready stream tagged with its channel; sits between the rbus and the host packetizer.
// PARAMETERS
// - NCH       4  number of FIFO channels (1..16); BASE_ADDR+NCH-1 <= 255
// - BASE_ADDR 0  rbus address of channel 0
// - BURST     4  max words per grant (1..255)
// - RD_LAT    1  cycles from strobe edge to byte valid on rbus_data (1..3)
// PORTS
// - clock       in  1         system clock; top level also drives it onto FIFO rd_clk / rbus clkbus
// - reset_n     in  1         async assert, active-low; deassert synchronised externally
// - enable      in  1         1 = scheduling allowed
// - chan_mask   in  NCH       per-channel request enable
// - chan_empty  in  NCH       FIFO empty flags
// - rbus_ctrl   out 12        {addr[7:0], readEnable, writeEnable(=0), dataStrobe, clkbus(=0, merged at top)}
// - rbus_data   in  8         byte returned by addressed FIFO
// - word_out    out 32        assembled word
// - word_chan   out 4         channel index of word_out
// - word_valid  out 1         word_out/word_chan valid
// - word_ready  in  1         consumer accepts when valid&ready at clock edge
// - busy        out 1         1 in any state except IDLE
// - grant       out NCH       one-hot active channel, 0 in IDLE
// BEHAVIOUR
// - Reset: state=IDLE; rr_ptr=0; all outputs 0, including rbus_ctrl=12'h000, word_valid=0, grant=0.
// - Eligibility: req[i] = enable & chan_mask[i] & ~chan_empty[i].
// - Non-empty means >= 1 full word (4 bytes) is readable.
// - IDLE: any req -> ARB; otherwise stay, rbus_ctrl=0.
// - ARB (1 cycle): pick first req at index >= rr_ptr, wrapping NCH-1 -> 0; latch chan and grant.
//   - Set rr_ptr = chan+1 mod NCH; wcnt=0; go to SETUP.
//   - If req vanished, return to IDLE.
// - SETUP (1 cycle): addr=BASE_ADDR+chan, readEnable=1, dataStrobe=0.
// - STROBE (4 cycles): dataStrobe=1, bcnt 0..3; then DRAIN.
// - Capture: strobe pipe delayed RD_LAT cycles; each delayed strobe samples rbus_data.
//   - Capture k (k=0..3) goes to word[31-8k -: 8]; first byte is the MSB.
// - DRAIN: hold addr+readEnable, dataStrobe=0, until 4th capture; then HOLD with word_valid=1.
// - Latency: ARB at cycle t -> word_valid at t+6+RD_LAT.
// - HOLD: readEnable=0, dataStrobe=0; word_out, word_chan stable while valid&~ready (backpressure, no strobes).
// - On valid&ready: wcnt++, word_valid=0 next cycle.
//   - If wcnt<BURST & enable & chan_mask[chan] & ~chan_empty[chan] -> SETUP (same chan); else -> IDLE.
// - Empty is sampled only in ARB and at HOLD exit, always >= RD_LAT+1 cycles after the last strobe, so the flag has settled.
// - enable or chan_mask dropped mid-word: current word completes and is delivered, then IDLE. Never abort partway through a word.
// - chan_empty rising mid-word: ignored (word is already resident).
// - Reset mid-operation: immediate return to reset values.
//   - FIFOs share the reset, so byte alignment is restored.
// - writeEnable is always 0. The addr field is 0 whenever readEnable=0.
// STRUCTURE
// - Shared package wca_rbus_pkg: rbus_ctrl bit positions (CLK=0, STB=1, WE=2, RE=3, ADDR=11:4), state encoding localparams.
// - Sub-module wca_rr_arbiter (NCH, req, ptr -> onehot, idx, any): combinational rotate-priority pick, reusable by other rbus masters.
// - Remainder: FSM, wcnt/bcnt counters, RD_LAT strobe delay line, byte assembly register.
// TESTING
// - Bench models FIFOs as 32w/8r MSB-first queues with RD_LAT=1, and wraps rbus_data per channel.
// - Single word: ch1 holds 32'hA1B2C3D4, mask=4'hF, ready=1.
//   -> addr 8'h01 rbus cycles, word_out=A1B2C3D4, word_chan=1, valid at ARB+7, then IDLE.
// - Round-robin: ch0, ch2 each hold 8 words, BURST=4.
//   -> grant order ch0(4 words), ch2(4), ch0(4), ch2(4); rr_ptr wrap checked.
// - Backpressure: word_ready=0 for 10 cycles in HOLD.
//   -> word_out stable, dataStrobe=0 and readEnable=0 throughout; resumes on ready.
// - Early release: ch3 holds 2 words, BURST=4 -> 2 words delivered, IDLE after 2nd handshake, no extra strobes.
// - Disable mid-word: enable=0 during STROBE bcnt=2.
//   -> word completes and is delivered, then IDLE; no new ARB until enable=1.
// - Reset mid-DRAIN: reset_n low -> rbus_ctrl=0, word_valid=0, grant=0 same cycle.
//   -> after release and FIFO refill, the first word is correct.

Source files
------------

// File: rtl/wca_rbus_pkg.sv
// Shared definitions for rbus masters: control-word bit positions and the
// scheduler state encoding.
package wca_rbus_pkg;

    localparam int RBUS_CLK      = 0;
    localparam int RBUS_STB      = 1;
    localparam int RBUS_WE       = 2;
    localparam int RBUS_RE       = 3;
    localparam int RBUS_ADDR_LSB = 4;
    localparam int RBUS_ADDR_MSB = 11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARB    = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_HOLD   = 3'd5
    } sched_state_t;

    // Read-only master: writeEnable and clkbus are always driven low here.
    function automatic logic [11:0] rbus_pack(input logic [7:0] addr,
                                              input logic re,
                                              input logic stb);
        logic [11:0] ctrl;
        ctrl = '0;
        ctrl[RBUS_ADDR_MSB:RBUS_ADDR_LSB] = addr;
        ctrl[RBUS_RE]  = re;
        ctrl[RBUS_STB] = stb;
        return ctrl;
    endfunction

endpackage

// File: rtl/wca_rr_arbiter.sv
// Combinational rotate-priority arbiter: first request at index >= ptr,
// wrapping from NCH-1 back to 0.
module wca_rr_arbiter #(
    parameter int NCH = 4,
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic [NCH-1:0] onehot,
    output logic [IW-1:0]  idx,
    output logic           any
);

    int j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        for (int k = 0; k < NCH; k++) begin
            j = int'(ptr) + k;
            if (j >= NCH) j = j - NCH;
            if (!any && req[j]) begin
                any       = 1'b1;
                idx       = IW'(j);
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wca_rbus_fifo_sched.sv
// Round-robin rbus master draining byte-wide read FIFOs into a channel-tagged
// 32-bit word stream.
module wca_rbus_fifo_sched
    import wca_rbus_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int BASE_ADDR = 0,
    parameter int BURST     = 4,
    parameter int RD_LAT    = 1
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           enable,
    input  logic [NCH-1:0] chan_mask,
    input  logic [NCH-1:0] chan_empty,
    output logic [11:0]    rbus_ctrl,
    input  logic [7:0]     rbus_data,
    output logic [31:0]    word_out,
    output logic [3:0]     word_chan,
    output logic           word_valid,
    input  logic           word_ready,
    output logic           busy,
    output logic [NCH-1:0] grant
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    sched_state_t      state_reg, state_next;
    logic [IW-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [IW-1:0]     chan_reg, chan_next;
    logic [NCH-1:0]    grant_reg, grant_next;
    logic [7:0]        wcnt_reg, wcnt_next;
    logic [1:0]        bcnt_reg, bcnt_next;
    logic [1:0]        ccnt_reg;
    logic [RD_LAT-1:0] stb_pipe_reg;
    logic [31:0]       word_reg;

    logic [NCH-1:0]    req;
    logic [NCH-1:0]    arb_onehot;
    logic [IW-1:0]     arb_idx;
    logic              arb_any;
    logic              re, stb, capture, more;

    assign req     = {NCH{enable}} & chan_mask & ~chan_empty;
    assign capture = stb_pipe_reg[RD_LAT-1];
    assign more    = ({1'b0, wcnt_reg} + 9'd1) < 9'(BURST);

    wca_rr_arbiter #(.NCH(NCH)) u_arb (
        .req    (req),
        .ptr    (rr_ptr_reg),
        .onehot (arb_onehot),
        .idx    (arb_idx),
        .any    (arb_any)
    );

    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        chan_next   = chan_reg;
        grant_next  = grant_reg;
        wcnt_next   = wcnt_reg;
        bcnt_next   = bcnt_reg;
        re          = 1'b0;
        stb         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (|req) state_next = ST_ARB;
            end
            ST_ARB: begin
                if (arb_any) begin
                    chan_next   = arb_idx;
                    grant_next  = arb_onehot;
                    rr_ptr_next = (arb_idx == IW'(NCH - 1)) ? '0 : arb_idx + 1'b1;
                    wcnt_next   = '0;
                    state_next  = ST_SETUP;
                end else begin
                    state_next  = ST_IDLE;
                end
            end
            ST_SETUP: begin
                re         = 1'b1;
                bcnt_next  = '0;
                state_next = ST_STROBE;
            end
            ST_STROBE: begin
                re        = 1'b1;
                stb       = 1'b1;
                bcnt_next = bcnt_reg + 1'b1;
                if (bcnt_reg == 2'd3) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                re = 1'b1;
                if (capture && ccnt_reg == 2'd3) state_next = ST_HOLD;
            end
            ST_HOLD: begin
                // Eligibility is re-sampled only here, once the word is whole,
                // so a dropped enable/mask never truncates a word.
                if (word_ready) begin
                    wcnt_next = wcnt_reg + 1'b1;
                    if (more && req[chan_reg]) begin
                        state_next = ST_SETUP;
                    end else begin
                        state_next = ST_IDLE;
                        grant_next = '0;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            rr_ptr_reg   <= '0;
            chan_reg     <= '0;
            grant_reg    <= '0;
            wcnt_reg     <= '0;
            bcnt_reg     <= '0;
            ccnt_reg     <= '0;
            stb_pipe_reg <= '0;
            word_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            chan_reg   <= chan_next;
            grant_reg  <= grant_next;
            wcnt_reg   <= wcnt_next;
            bcnt_reg   <= bcnt_next;
            for (int k = RD_LAT - 1; k > 0; k--) stb_pipe_reg[k] <= stb_pipe_reg[k-1];
            stb_pipe_reg[0] <= stb;
            if (state_reg == ST_SETUP) ccnt_reg <= '0;
            else if (capture)          ccnt_reg <= ccnt_reg + 1'b1;
            // Shift-in leaves the first captured byte in the MSB after four captures.
            if (capture) word_reg <= {word_reg[23:0], rbus_data};
        end
    end

    assign rbus_ctrl  = rbus_pack(re ? 8'(BASE_ADDR) + 8'(chan_reg) : 8'h00, re, stb);
    assign word_out   = word_reg;
    assign word_chan  = 4'(chan_reg);
    assign word_valid = (state_reg == ST_HOLD);
    assign busy       = (state_reg != ST_IDLE);
    assign grant      = grant_reg;

endmodule

// File: tb/tb_wca_rbus_fifo_sched.sv
// Directed bench: byte-FIFO models with one-cycle read latency behind the rbus,
// table-driven single-word vectors plus multi-cycle corner sequences.
module tb_wca_rbus_fifo_sched;

    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b0;
    logic           word_ready = 1'b1;
    logic [NCH-1:0] chan_mask = '0;
    logic [NCH-1:0] chan_empty;
    logic [11:0]    rbus_ctrl;
    logic [7:0]     rbus_data;
    logic [31:0]    word_out;
    logic [3:0]     word_chan;
    logic           word_valid, busy;
    logic [NCH-1:0] grant;

    always #5 clk = ~clk;

    wca_rbus_fifo_sched #(.NCH(NCH), .BASE_ADDR(0), .BURST(4), .RD_LAT(1)) dut (
        .clock      (clk),
        .reset_n    (rst_n),
        .enable     (enable),
        .chan_mask  (chan_mask),
        .chan_empty (chan_empty),
        .rbus_ctrl  (rbus_ctrl),
        .rbus_data  (rbus_data),
        .word_out   (word_out),
        .word_chan  (word_chan),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy),
        .grant      (grant)
    );

    // FIFO models: wr/mem owned by the stimulus process, rd/dout by the rbus side.
    logic [7:0] mem [NCH][64];
    int         wr [NCH];
    int         rd [NCH];
    logic [7:0] dout [NCH];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                rd[i]   <= 0;
                dout[i] <= 8'h00;
            end
        end else if (rbus_ctrl[3] && rbus_ctrl[1]) begin
            dout[rbus_ctrl[5:4]] <= mem[rbus_ctrl[5:4]][rd[rbus_ctrl[5:4]] % 64];
            rd[rbus_ctrl[5:4]]   <= rd[rbus_ctrl[5:4]] + 1;
        end
    end

    assign rbus_data = dout[rbus_ctrl[5:4]];

    always_comb begin
        chan_empty = '0;
        for (int i = 0; i < NCH; i++) chan_empty[i] = (wr[i] - rd[i]) < 4;
    end

    // Bus / stream monitor, sampled on the falling edge.
    int          cyc = 0;
    int          n_got, n_stb, n_arb, bad_we, bad_addr, arb_cyc, valid_cyc;
    logic [7:0]  last_addr;
    logic [31:0] got_w [32];
    logic [3:0]  got_c [32];
    logic [NCH-1:0] got_g [32];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            n_got = 0; n_stb = 0; n_arb = 0; bad_we = 0; bad_addr = 0;
            arb_cyc = -1; valid_cyc = -1; last_addr = 8'hFF;
        end else begin
            if (busy && grant == '0) begin
                n_arb++;
                if (arb_cyc < 0) arb_cyc = cyc;
            end
            if (word_valid && valid_cyc < 0) valid_cyc = cyc;
            if (rbus_ctrl[1]) n_stb++;
            if (rbus_ctrl[2]) bad_we++;
            if (!rbus_ctrl[3] && rbus_ctrl[11:4] != 8'h00) bad_addr++;
            if (rbus_ctrl[3]) last_addr = rbus_ctrl[11:4];
            if (word_valid && word_ready && n_got < 32) begin
                got_w[n_got] = word_out;
                got_c[n_got] = word_chan;
                got_g[n_got] = grant;
                n_got++;
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input int ch, input logic [31:0] w);
        for (int b = 0; b < 4; b++) begin
            mem[ch][(wr[ch] + b) % 64] = w[31-8*b -: 8];
        end
        wr[ch] = wr[ch] + 4;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; enable = 1'b0; chan_mask = '0; word_ready = 1'b1;
        for (int i = 0; i < NCH; i++) wr[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {rbus_ctrl, word_valid, grant, busy, word_out, word_chan},
            64'h0);
        rst_n = 1'b1;
    endtask

    task automatic wait_got(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (n_got < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (n_got < n) begin
            errors++;
            $display("FAIL %s_timeout: got %0d words, expected %0d", name, n_got, n);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k;
        k = 0;
        @(posedge clk); #1;
        while (busy && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        chk({name, "_idle"}, 64'(busy), 64'h0);
    endtask

    typedef struct {
        int          ch;
        logic [31:0] w;
        logic [7:0]  exp_addr;
        logic [3:0]  exp_grant;
        int          exp_lat;
    } vec_t;

    vec_t vecs [4];

    initial begin
        logic [31:0] exp_w;
        int          exp_c;
        int          viol;
        int          stb0;

        vecs[0] = '{ch: 1, w: 32'hA1B2C3D4, exp_addr: 8'h01, exp_grant: 4'b0010, exp_lat: 7};
        vecs[1] = '{ch: 0, w: 32'h01234567, exp_addr: 8'h00, exp_grant: 4'b0001, exp_lat: 7};
        vecs[2] = '{ch: 3, w: 32'hDEADBEEF, exp_addr: 8'h03, exp_grant: 4'b1000, exp_lat: 7};
        vecs[3] = '{ch: 2, w: 32'h80FF0001, exp_addr: 8'h02, exp_grant: 4'b0100, exp_lat: 7};

        // Single-word transactions from a fresh reset.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            push_word(vecs[v].ch, vecs[v].w);
            chan_mask = 4'hF;
            enable    = 1'b1;
            wait_got(1, 50, "single");
            wait_idle(20, "single");
            chk("single_word",    64'(got_w[0]), 64'(vecs[v].w));
            chk("single_chan",    64'(got_c[0]), 64'(vecs[v].ch));
            chk("single_grant",   64'(got_g[0]), 64'(vecs[v].exp_grant));
            chk("single_latency", 64'(valid_cyc - arb_cyc), 64'(vecs[v].exp_lat));
            chk("single_addr",    64'(last_addr), 64'(vecs[v].exp_addr));
            chk("single_strobes", 64'(n_stb), 64'd4);
            $display("vec %0d: ch=%0d word=%08h lat=%0d", v, vecs[v].ch, got_w[0],
                     valid_cyc - arb_cyc);
        end

        // Round-robin between ch0 and ch2, four words per grant.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            push_word(0, 32'hC000_0000 + 32'(k));
            push_word(2, 32'hC200_0000 + 32'(k));
        end
        chan_mask = 4'hF;
        enable    = 1'b1;
        wait_got(16, 1000, "rr");
        wait_idle(20, "rr");
        for (int i = 0; i < 16; i++) begin
            exp_c = ((i / 4) % 2 == 0) ? 0 : 2;
            exp_w = ((exp_c == 0) ? 32'hC000_0000 : 32'hC200_0000) + 32'((i / 8) * 4 + i % 4);
            chk("rr_chan", 64'(got_c[i]), 64'(exp_c));
            chk("rr_word", 64'(got_w[i]), 64'(exp_w));
            $display("rr %0d: ch=%0d word=%08h", i, got_c[i], got_w[i]);
        end
        chk("rr_arb_count", 64'(n_arb), 64'd4);

        // Backpressure held for ten cycles in HOLD.
        do_reset();
        push_word(1, 32'h11223344);
        push_word(1, 32'h55667788);
        word_ready = 1'b0;
        chan_mask  = 4'hF;
        enable     = 1'b1;
        for (int k = 0; k < 50 && !word_valid; k++) begin
            @(posedge clk); #1;
        end
        chk("bp_valid", 64'(word_valid), 64'h1);
        viol = 0;
        stb0 = n_stb;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (word_out !== 32'h11223344 || !word_valid || rbus_ctrl[3:1] != 3'b000) viol++;
        end
        chk("bp_stable", 64'(viol), 64'h0);
        chk("bp_no_strobe", 64'(n_stb - stb0), 64'h0);
        word_ready = 1'b1;
        wait_got(2, 50, "bp");
        chk("bp_word0", 64'(got_w[0]), 64'h11223344);
        chk("bp_word1", 64'(got_w[1]), 64'h55667788);
        $display("bp: words %08h %08h", got_w[0], got_w[1]);

        // Early release: two words available with a burst limit of four.
        do_reset();
        push_word(3, 32'h33330001);
        push_word(3, 32'h33330002);
        chan_mask = 4'hF;
        enable    = 1'b1;
        wait_got(2, 100, "early");
        wait_idle(20, "early");
        repeat (10) @(posedge clk);
        #1;
        chk("early_count",   64'(n_got), 64'd2);
        chk("early_strobes", 64'(n_stb), 64'd8);
        chk("early_arbs",    64'(n_arb), 64'd1);
        chk("early_word1",   64'(got_w[1]), 64'h33330002);
        $display("early: %0d words, %0d strobes", n_got, n_stb);

        // Enable dropped during the third strobe of the first word.
        do_reset();
        push_word(0, 32'hE0000001);
        push_word(0, 32'hE0000002);
        push_word(0, 32'hE0000003);
        chan_mask = 4'hF;
        enable    = 1'b1;
        for (int k = 0; k < 50 && n_stb < 3; k++) begin
            @(negedge clk); #1;
        end
        chk("dis_at_bcnt2", 64'({rbus_ctrl[1], 32'(n_stb)}), 64'({1'b1, 32'd3}));
        enable = 1'b0;
        wait_got(1, 50, "dis");
        wait_idle(20, "dis");
        repeat (20) @(posedge clk);
        #1;
        chk("dis_count",   64'(n_got), 64'd1);
        chk("dis_word",    64'(got_w[0]), 64'hE0000001);
        chk("dis_strobes", 64'(n_stb), 64'd4);
        chk("dis_arbs",    64'(n_arb), 64'd1);
        enable = 1'b1;
        wait_got(3, 100, "dis_resume");
        chk("dis_word2", 64'(got_w[1]), 64'hE0000002);
        chk("dis_word3", 64'(got_w[2]), 64'hE0000003);
        chk("dis_arbs2", 64'(n_arb), 64'd2);
        $display("dis: %0d words after resume", n_got);

        // Reset asserted during DRAIN, then a clean refill.
        do_reset();
        push_word(2, 32'hBAD0BAD0);
        chan_mask = 4'hF;
        enable    = 1'b1;
        for (int k = 0; k < 50 && !(n_stb == 4 && rbus_ctrl[3] && !rbus_ctrl[1]); k++) begin
            @(negedge clk); #1;
        end
        chk("rst_in_drain", 64'({rbus_ctrl[3], rbus_ctrl[1]}), 64'b10);
        rst_n = 1'b0;
        #1;
        chk("rst_async", 64'({rbus_ctrl, word_valid, grant, busy}), 64'h0);
        for (int i = 0; i < NCH; i++) wr[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_word(2, 32'h13579BDF);
        wait_got(1, 50, "rst");
        chk("rst_word", 64'(got_w[0]), 64'h13579BDF);
        chk("rst_chan", 64'(got_c[0]), 64'd2);
        $display("rst: refill word %08h", got_w[0]);

        chk("never_write", 64'(bad_we), 64'h0);
        chk("addr_zero_no_re", 64'(bad_addr), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
